// File: rtl/jt89_cmdq_pkg.sv
// jt89_cmdq shared types and constants.
// Optional overflow tracking is enabled with JT89_CMDQ_OVF_EN.
package jt89_cmdq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_GAP
  } state_e;

  localparam int LOW_W = 4;
  localparam int GAP_W = 8;

  localparam logic [7:0] DROP_SAT = 8'd255;

endpackage

// File: rtl/jt89_cmdq_fifo.sv
// jt89_cmdq byte FIFO: extra pointer bit separates full from empty.
// Flush wins over push and pop in the same cycle.
module jt89_cmdq_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int N = 1 << AW;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [N];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          wr_en, rd_en;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign wr_en = push_i && !full_o && !flush_i;
  assign rd_en = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ONE;
      if (rd_en) rptr_d = rptr_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/jt89_cmdq.sv
// jt89_cmdq: CPU write queue replaying bytes to jt89 wr_n/din.
// Define JT89_CMDQ_OVF_EN to build the ovf / drop_cnt tracking.
module jt89_cmdq
  import jt89_cmdq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int LOW_CYC    = 2,
  parameter int GAP_CEN    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_din,
  input  logic                  flush,
  output logic                  cpu_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  psg_wr_n,
  output logic [7:0]            psg_din,
  output logic                  ovf,
  output logic [7:0]            drop_cnt
);

  state_e           state_q, state_d;
  logic [LOW_W-1:0] lcnt_q, lcnt_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             wr_n_q, wr_n_d;
  logic [7:0]       din_q, din_d;
  logic             pop;
  logic [7:0]       head;
  logic             full, empty;

  jt89_cmdq_fifo #(
    .AW (DEPTH_LOG2),
    .DW (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cpu_wr),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (cpu_din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign cpu_ready = !full;
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign psg_wr_n  = wr_n_q;
  assign psg_din   = din_q;

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    gcnt_d  = gcnt_q;
    wr_n_d  = wr_n_q;
    din_d   = din_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_n_d = 1'b1;
        // A flushed head is never replayed.
        if (!empty && !flush) begin
          pop     = 1'b1;
          din_d   = head;
          lcnt_d  = LOW_W'(LOW_CYC - 1);
          wr_n_d  = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (lcnt_q == '0) begin
          gcnt_d  = GAP_W'(GAP_CEN);
          wr_n_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (clk_en) begin
          gcnt_d = gcnt_q - 1'b1;
          if (gcnt_q <= GAP_W'(1)) state_d = ST_IDLE;
        end
      end
      default: begin
        wr_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lcnt_q  <= '0;
      gcnt_q  <= '0;
      wr_n_q  <= 1'b1;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      gcnt_q  <= gcnt_d;
      wr_n_q  <= wr_n_d;
      din_q   <= din_d;
    end
  end

`ifdef JT89_CMDQ_OVF_EN
  logic       ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  logic       drop;

  // Fullness is sampled before the edge, so a same-cycle pop does not help.
  assign drop = cpu_wr && full && !flush;

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_SAT) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;
`else
  assign ovf      = 1'b0;
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jt89_cmdq.sv
// Bench for jt89_cmdq: scoreboard of accepted bytes checked
// against every falling edge of psg_wr_n.
module tb_jt89_cmdq;

`ifdef JT89_CMDQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_din = 8'd0;
  logic       flush = 1'b0;
  logic       cpu_ready;
  logic [3:0] level;
  logic       busy;
  logic       psg_wr_n;
  logic [7:0] psg_din;
  logic       ovf;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ce_div = 1;
  int ce_cnt = 0;
  int fall_cnt = 0;
  int max_level = 0;
  int push_cyc = 0;
  int fall_q[$];
  int rise_q[$];
  logic [7:0] sb[$];
  logic       prev_wr_n = 1'b1;
  logic [7:0] low_din = 8'd0;

  jt89_cmdq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .cpu_wr    (cpu_wr),
    .cpu_din   (cpu_din),
    .flush     (flush),
    .cpu_ready (cpu_ready),
    .level     (level),
    .busy      (busy),
    .psg_wr_n  (psg_wr_n),
    .psg_din   (psg_din),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    clk_en = (ce_div != 0) && ((ce_cnt % ce_div) == 0);
    ce_cnt = ce_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr_n = 1'b1;
    end else begin
      if (prev_wr_n && !psg_wr_n) begin
        fall_cnt = fall_cnt + 1;
        fall_q.push_back(cyc);
        low_din = psg_din;
        tests = tests + 1;
        if (sb.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_pulse din=%02h required no pulse",
                   psg_din);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (psg_din !== exp) begin
            fails = fails + 1;
            $display("FAIL pulse_data got=%02h exp=%02h", psg_din, exp);
          end
        end
      end else if (!prev_wr_n && !psg_wr_n) begin
        tests = tests + 1;
        if (psg_din !== low_din) begin
          fails = fails + 1;
          $display("FAIL din_stable got=%02h exp=%02h", psg_din, low_din);
        end
      end
      if (!prev_wr_n && psg_wr_n) rise_q.push_back(cyc);
      if (int'(level) > max_level) max_level = int'(level);
      prev_wr_n = psg_wr_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    cpu_wr = 1'b1;
    cpu_din = b;
    if (acc) sb.push_back(b);
    tick();
    cpu_wr = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_falls(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (fall_cnt < n && k < budget) begin
      tick();
      k++;
    end
    ok = (fall_cnt >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    ok = (busy === 1'b0) && (sb.size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests += 7;
    if (psg_wr_n !== 1'b1) begin
      fails++; $display("FAIL rst_wr_n got=%b exp=1", psg_wr_n);
    end
    if (psg_din !== 8'h00) begin
      fails++; $display("FAIL rst_din got=%02h exp=00", psg_din);
    end
    if (cpu_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready got=%b exp=1", cpu_ready);
    end
    if (level !== 4'd0) begin
      fails++; $display("FAIL rst_level got=%0d exp=0", level);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL rst_ovf got=%b exp=0", ovf);
    end
    if (drop_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt);
    end
  endtask

  task automatic test_single();
    bit ok;
    int busy_cyc, k;
    ce_div = 1;
    fall_q.delete();
    rise_q.delete();
    push(8'h9F, 1'b1);
    wait_falls(fall_cnt + 1, 20, ok);
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    busy_cyc = cyc;
    tests += 4;
    if (!ok || busy !== 1'b0 || rise_q.size() != 1) begin
      fails++;
      $display("FAIL single_timeout falls=%0d rises=%0d exp 1/1",
               fall_q.size(), rise_q.size());
    end else begin
      if (fall_q[0] - push_cyc != 1) begin
        fails++;
        $display("FAIL single_latency got=%0d exp=1", fall_q[0] - push_cyc);
      end
      if (rise_q[0] - fall_q[0] != 2) begin
        fails++;
        $display("FAIL single_low got=%0d exp=2", rise_q[0] - fall_q[0]);
      end
      if (busy_cyc - rise_q[0] != 32) begin
        fails++;
        $display("FAIL single_gap got=%0d exp=32", busy_cyc - rise_q[0]);
      end
    end
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] bytes [4];
    int base;
    bytes = '{8'h80, 8'h0A, 8'h90, 8'hE4};
    ce_div = 1;
    fall_q.delete();
    max_level = 0;
    base = fall_cnt;
    foreach (bytes[i]) push(bytes[i], 1'b1);
    wait_falls(base + 4, 400, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL burst_timeout falls=%0d exp=4", fall_cnt - base);
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (fall_q[i] - fall_q[i-1] != 35) begin
          fails++;
          $display("FAIL burst_spacing%0d got=%0d exp=35", i,
                   fall_q[i] - fall_q[i-1]);
        end
      end
    end
    tests++;
    if (max_level != 3) begin
      fails++;
      $display("FAIL burst_peak_level got=%0d exp=3", max_level);
    end
    wait_idle(100, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL burst_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    ce_div = 0;
    tick();
    for (int i = 0; i < 10; i++) push(8'h10 + 8'(i), i < 9);
    tick();
    tests += 5;
    if (level !== 4'd8) begin
      fails++; $display("FAIL ovf_level got=%0d exp=8", level);
    end
    if (cpu_ready !== 1'b0) begin
      fails++; $display("FAIL ovf_ready got=%b exp=0", cpu_ready);
    end
    if (ovf !== OVF_EN) begin
      fails++; $display("FAIL ovf_flag got=%b exp=%b", ovf, OVF_EN);
    end
    if (drop_cnt !== (OVF_EN ? 8'd1 : 8'd0)) begin
      fails++;
      $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt,
               OVF_EN ? 1 : 0);
    end
    if (busy !== 1'b1) begin
      fails++; $display("FAIL ovf_stall_busy got=%b exp=1", busy);
    end
    ce_div = 1;
    wait_idle(500, ok);
    tests += 2;
    if (!ok) begin
      fails++; $display("FAIL ovf_drain left=%0d exp=0", sb.size());
    end
    if (level !== 4'd0 || cpu_ready !== 1'b1) begin
      fails++;
      $display("FAIL ovf_after_drain level=%0d ready=%b exp 0/1",
               level, cpu_ready);
    end
  endtask

  task automatic test_gap_gating();
    bit ok;
    int d;
    ce_div = 4;
    fall_q.delete();
    rise_q.delete();
    push(8'hC3, 1'b1);
    push(8'h5A, 1'b1);
    wait_falls(fall_cnt + 2, 400, ok);
    tests++;
    if (fall_q.size() < 2 || rise_q.size() < 1) begin
      fails++;
      $display("FAIL gate_timeout falls=%0d exp=2", fall_q.size());
    end else begin
      // 32 enables every 4 cycles plus one IDLE cycle; phase sets +-3.
      d = fall_q[1] - rise_q[0];
      if (d < 126 || d > 129) begin
        fails++; $display("FAIL gate_spacing got=%0d exp=126..129", d);
      end
    end
    ce_div = 1;
    wait_idle(100, ok);
  endtask

  task automatic test_flush_reset();
    bit ok;
    int base;
    ce_div = 1;
    fall_q.delete();
    rise_q.delete();
    base = fall_cnt;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b1);
    flush = 1'b1;
    cpu_wr = 1'b1;
    cpu_din = 8'h55;
    tick();
    flush = 1'b0;
    cpu_wr = 1'b0;
    sb.delete();
    tests++;
    if (level !== 4'd0) begin
      fails++; $display("FAIL flush_level got=%0d exp=0", level);
    end
    repeat (100) tick();
    tests += 3;
    if (fall_cnt - base != 1) begin
      fails++;
      $display("FAIL flush_pulses got=%0d exp=1", fall_cnt - base);
    end
    if (rise_q.size() != 1) begin
      fails++;
      $display("FAIL flush_pulse_done rises=%0d exp=1", rise_q.size());
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL flush_busy got=%b exp=0", busy);
    end
    base = fall_cnt;
    push(8'h3C, 1'b1);
    push(8'h3D, 1'b1);
    push(8'h3E, 1'b1);
    wait_falls(base + 1, 10, ok);
    tests++;
    if (!ok || psg_wr_n !== 1'b0) begin
      fails++; $display("FAIL rst_setup wr_n=%b exp=0", psg_wr_n);
    end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    tests += 4;
    if (psg_wr_n !== 1'b1) begin
      fails++; $display("FAIL async_rst_wr_n got=%b exp=1", psg_wr_n);
    end
    if (level !== 4'd0) begin
      fails++; $display("FAIL async_rst_level got=%0d exp=0", level);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL async_rst_busy got=%b exp=0", busy);
    end
    if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL async_rst_ovf ovf=%b drop=%0d exp 0/0", ovf, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    tests++;
    if (fall_cnt != base + 1) begin
      fails++;
      $display("FAIL rst_discard pulses=%0d exp=1", fall_cnt - base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d exp finish earlier", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_gap_gating();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
